cpu_bus_slave: RTL and testbench

- Responder end of the pulsed CPU bus: consumes single-cycle cpu_wr/cpu_rd requests with byte enables, a 4-bit address and 32-bit write data.
- Performs each access on an internal 16 x 32-bit register bank after a programmable access latency.
- Returns read data with a one-cycle valid strobe, and signals bus availability on trans_over.
- Sits between the CPU-side request generator and the peripheral register space; models a slow target.

---
 rtl/cpu_bus_slave_if.sv | 21 ++
 rtl/cpu_bus_slave.sv | 119 +++++++++++
 tb/tb_cpu_bus_slave.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_slave_if.sv
// Pulsed CPU bus between a request generator (master) and a slow register target (slave).
interface cpu_bus_slave_if;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [3:0]  cpu_byte;
    logic [3:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_rdata_v;
    logic [31:0] cpu_rdata;
    logic        trans_over;

    modport master (
        output cpu_wr, cpu_rd, cpu_byte, cpu_addr, cpu_wdata,
        input  cpu_rdata_v, cpu_rdata, trans_over
    );

    modport slave (
        input  cpu_wr, cpu_rd, cpu_byte, cpu_addr, cpu_wdata,
        output cpu_rdata_v, cpu_rdata, trans_over
    );
endinterface

// File: rtl/cpu_bus_slave.sv
// Slow 16x32 register-bank target: IDLE -> BUSY (WAIT_CYCLES) -> DONE per access.
// Optional CPU_SLV_STAT_REG_EN turns address 4'hF into a read-only completed-transaction count.
module cpu_bus_slave #(
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    cpu_bus_slave_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        accept;
    logic        is_wr_q;
    logic [3:0]  addr_q;
    logic [3:0]  byte_q;
    logic [31:0] wdata_q;
    logic [31:0] regs_q [16];
    logic [31:0] rdata_q;
    logic        rdata_v_q;
    logic [31:0] lane_mask;
    logic [31:0] rd_val;
    logic        last_busy;
    logic        commit_wr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cpu_wr || bus.cpu_rd) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                    cnt_d   = 8'(WAIT_CYCLES);
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request fields are captured only on acceptance so later bus changes cannot leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            byte_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            is_wr_q <= bus.cpu_wr;
            addr_q  <= bus.cpu_addr;
            byte_q  <= bus.cpu_byte;
            wdata_q <= bus.cpu_wdata;
        end
    end

    always_comb begin
        for (int b = 0; b < 4; b++) lane_mask[8*b +: 8] = {8{byte_q[b]}};
    end

    assign last_busy = (state_q == BUSY) && (cnt_q == 8'd1);

`ifdef CPU_SLV_STAT_REG_EN
    logic [31:0] stat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              stat_q <= '0;
        else if (state_q == DONE) stat_q <= stat_q + 32'd1;
    end

    assign rd_val    = (addr_q == 4'hF) ? stat_q : regs_q[addr_q];
    assign commit_wr = (state_q == DONE) && is_wr_q && (addr_q != 4'hF);
`else
    assign rd_val    = regs_q[addr_q];
    assign commit_wr = (state_q == DONE) && is_wr_q;
`endif

    // Read data is registered on entry to DONE so the valid strobe and data line up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q   <= '0;
            rdata_v_q <= 1'b0;
        end else begin
            rdata_v_q <= last_busy && !is_wr_q;
            if (last_busy && !is_wr_q) rdata_q <= rd_val & lane_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else if (commit_wr) begin
            for (int b = 0; b < 4; b++)
                if (byte_q[b]) regs_q[addr_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
    end

    assign bus.trans_over  = (state_q == IDLE);
    assign bus.cpu_rdata_v = rdata_v_q;
    assign bus.cpu_rdata   = rdata_q;

endmodule

// File: tb/tb_cpu_bus_slave.sv
// Randomized bench for cpu_bus_slave with a per-cycle transaction-timeline reference model.
module tb_cpu_bus_slave;

    localparam int W = 3;

    logic clk;
    logic rst_n;
    cpu_bus_slave_if bif ();

    cpu_bus_slave #(.WAIT_CYCLES(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] b);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{b[i]}};
        return m;
    endfunction

    // Reference model: a transaction accepted in cycle t0 owns cycles t0+1..t0+W+1,
    // the last of which delivers read data or commits the write.
    logic [31:0] mem [16];
    logic [31:0] m_stat;
    logic [31:0] e_rdata;
    bit          active;
    bit          m_wr;
    logic [3:0]  m_addr, m_byte;
    logic [31:0] m_wdata;
    int          t0;
    int          cyc = 0;

    initial begin
        bit done_now, e_v, e_to;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                for (int i = 0; i < 16; i++) mem[i] = '0;
                m_stat  = '0;
                e_rdata = '0;
                active  = 0;
                chk("reset_trans_over", {31'd0, bif.trans_over}, 32'd1);
                chk("reset_rdata_v", {31'd0, bif.cpu_rdata_v}, 32'd0);
                chk("reset_rdata", bif.cpu_rdata, 32'd0);
            end else begin
                done_now = active && (cyc == t0 + W + 1);
                e_v = 0;
                if (done_now && !m_wr) begin
                    e_v = 1;
`ifdef CPU_SLV_STAT_REG_EN
                    if (m_addr == 4'hF) e_rdata = m_stat & bmask(m_byte);
                    else                e_rdata = mem[m_addr] & bmask(m_byte);
`else
                    e_rdata = mem[m_addr] & bmask(m_byte);
`endif
                end
                e_to = !(active && cyc > t0 && cyc <= t0 + W + 1);
                chk("trans_over", {31'd0, bif.trans_over}, {31'd0, e_to});
                chk("rdata_v", {31'd0, bif.cpu_rdata_v}, {31'd0, e_v});
                chk("rdata", bif.cpu_rdata, e_rdata);
                if (done_now) begin
                    if (m_wr) begin
`ifdef CPU_SLV_STAT_REG_EN
                        if (m_addr != 4'hF)
                            mem[m_addr] = (mem[m_addr] & ~bmask(m_byte)) | (m_wdata & bmask(m_byte));
`else
                        mem[m_addr] = (mem[m_addr] & ~bmask(m_byte)) | (m_wdata & bmask(m_byte));
`endif
                    end
                    m_stat = m_stat + 32'd1;
                    active = 0;
                end else if (e_to && (bif.cpu_wr || bif.cpu_rd)) begin
                    active  = 1;
                    t0      = cyc;
                    m_wr    = bif.cpu_wr;
                    m_addr  = bif.cpu_addr;
                    m_byte  = bif.cpu_byte;
                    m_wdata = bif.cpu_wdata;
                end
            end
        end
    end

    // Stimulus: inputs change 1 time unit after each posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit wr, input bit rd, input logic [3:0] a,
                         input logic [3:0] b, input logic [31:0] d);
        bif.cpu_wr    = wr;
        bif.cpu_rd    = rd;
        bif.cpu_addr  = a;
        bif.cpu_byte  = b;
        bif.cpu_wdata = d;
    endtask

    task automatic scramble();
        drive(0, 0, 4'($urandom), 4'($urandom), $urandom);
    endtask

    task automatic wait_idle(output bit saw_v);
        bit ok;
        ok    = 0;
        saw_v = 0;
        for (int k = 0; k < 600; k++) begin
            tick();
            if (bif.cpu_rdata_v) saw_v = 1;
            if (bif.trans_over) begin ok = 1; break; end
        end
        chk("idle_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic xact(input bit wr, input bit rd, input logic [3:0] a,
                        input logic [3:0] b, input logic [31:0] d, output bit saw_v);
        drive(wr, rd, a, b, d);
        tick();
        scramble();
        wait_idle(saw_v);
    endtask

    task automatic do_read(input string name, input logic [3:0] a, input logic [3:0] b,
                           input logic [31:0] exp);
        bit sv;
        xact(0, 1, a, b, 32'h0, sv);
        chk({name, "_v"}, {31'd0, sv}, 32'd1);
        chk(name, bif.cpu_rdata, exp);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [3:0] b, input logic [31:0] d);
        bit sv;
        xact(1, 0, a, b, d, sv);
        chk("write_no_v", {31'd0, sv}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    initial begin
        bit sv;
        logic [5:0] to_pat, v_pat;
        rst_n = 0;
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        rst_n = 1;
        tick();

        // 1: read addr 5 timing
        drive(0, 1, 4'd5, 4'hF, 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            to_pat[k] = bif.trans_over;
            v_pat[k]  = bif.cpu_rdata_v;
            if (k == 0) begin tick(); scramble(); end
        end
        chk("t1_trans_over_pattern", {26'd0, to_pat}, 32'b100001);
        chk("t1_rdata_v_pattern", {26'd0, v_pat}, 32'b010000);
        chk("t1_rdata", bif.cpu_rdata, 32'h0);
        tick();

        // 2, 3: full and partial writes / masked reads
        do_write(4'd2, 4'hF, 32'hA5A51234);
        do_read("t2_rd", 4'd2, 4'hF, 32'hA5A51234);
        do_write(4'd2, 4'b0101, 32'hFFFFFFFF);
        do_read("t3_rd_full", 4'd2, 4'hF, 32'hA5FF12FF);
        do_read("t3_rd_low", 4'd2, 4'b0011, 32'h000012FF);
        do_write(4'd7, 4'b0000, 32'hFFFFFFFF);
        do_read("byte0_rd", 4'd2, 4'b0000, 32'h0);

        // 4: request while busy is ignored; simultaneous wr+rd is a write
        drive(0, 1, 4'd0, 4'hF, 32'h0);
        tick();
        scramble();
        tick();
        drive(1, 0, 4'd3, 4'hF, 32'h11111111);
        tick();
        scramble();
        wait_idle(sv);
        do_read("t4_ignored", 4'd3, 4'hF, 32'h0);
        xact(1, 1, 4'd4, 4'hF, 32'h5, sv);
        chk("t4_wrrd_no_v", {31'd0, sv}, 32'd0);
        do_read("t4_wrrd_rb", 4'd4, 4'hF, 32'h00000005);

        // 5: reset in cycle 2 of a write
        drive(1, 0, 4'd6, 4'hF, 32'hDEADBEEF);
        tick();
        scramble();
        tick();
        rst_n = 0;
        #1;
        chk("t5_async_to", {31'd0, bif.trans_over}, 32'd1);
        chk("t5_async_v", {31'd0, bif.cpu_rdata_v}, 32'd0);
        chk("t5_async_rdata", bif.cpu_rdata, 32'd0);
        tick();
        tick();
        rst_n = 1;
        tick();
        do_read("t5_rd6", 4'd6, 4'hF, 32'h0);

        // 6: address 15
        do_reset();
`ifdef CPU_SLV_STAT_REG_EN
        do_write(4'd1, 4'hF, 32'h1);
        do_write(4'd2, 4'hF, 32'h2);
        do_read("t6_pre", 4'd1, 4'hF, 32'h1);
        do_read("t6_stat3", 4'hF, 4'hF, 32'd3);
        do_write(4'hF, 4'hF, 32'h0);
        do_read("t6_stat5", 4'hF, 4'hF, 32'd5);
`else
        do_write(4'hF, 4'hF, 32'h12345678);
        do_read("t6_r15", 4'hF, 4'hF, 32'h12345678);
`endif

        // Random traffic, including requests issued while busy
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            drive(r == 0 || r == 2, r == 1 || r == 2, 4'($urandom), 4'($urandom), $urandom);
            tick();
        end
        scramble();
        wait_idle(sv);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
